// File: rtl/pipeline_structs_defs.sv
// Shared pipeline types for the OTTER 5-stage core: branch-prediction status
// handed from DE, plus the hazard-recovery state and control bundles.
package pipeline_structs_defs;

    localparam int unsigned PC_SEL_W    = 3;
    localparam int unsigned FLUSH_CNT_W = 3;

    // Next-PC mux select for sequential fetch (PC + 4).
    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ = 3'd0;

    // Prediction outcome resolved in DE.
    typedef struct packed {
        logic [PC_SEL_W-1:0] pc_sel;
        logic                failed_prediction;
    } BRANCH_PREDICTION_STATUS_t;

    // Hazard controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } HAZARD_STATE_t;

    // Stall / flush / PC-enable bundle driven to the pipeline registers.
    typedef struct packed {
        logic pc_write;
        logic stall_if_de;
        logic stall_de_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_de;
        logic flush_de_ex;
    } HAZARD_CTRL_t;

    // Free-flowing pipeline.
    function automatic HAZARD_CTRL_t ctrl_normal();
        HAZARD_CTRL_t c;
        c          = '0;
        c.pc_write = 1'b1;
        return c;
    endfunction

    // Whole pipeline frozen while data memory is busy.
    function automatic HAZARD_CTRL_t ctrl_mem_hold();
        HAZARD_CTRL_t c;
        c              = '0;
        c.stall_if_de  = 1'b1;
        c.stall_de_ex  = 1'b1;
        c.stall_ex_mem = 1'b1;
        c.stall_mem_wb = 1'b1;
        return c;
    endfunction

    // Hold IF/DE and PC, push a bubble into EX behind the load.
    function automatic HAZARD_CTRL_t ctrl_load_use();
        HAZARD_CTRL_t c;
        c             = '0;
        c.stall_if_de = 1'b1;
        c.flush_de_ex = 1'b1;
        return c;
    endfunction

    // Redirect or wrong-path squash: PC advances, IF/DE gets a bubble.
    function automatic HAZARD_CTRL_t ctrl_flush();
        HAZARD_CTRL_t c;
        c             = '0;
        c.pc_write    = 1'b1;
        c.flush_if_de = 1'b1;
        return c;
    endfunction

    // Values presented while reset is held: everything squashed, PC frozen.
    function automatic HAZARD_CTRL_t ctrl_reset();
        HAZARD_CTRL_t c;
        c             = '0;
        c.flush_if_de = 1'b1;
        c.flush_de_ex = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Detects a DE instruction reading the destination of a load currently in EX.
// x0 is never a real dependency, so ex_rd == 0 never hits.
module load_use_detector #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  de_valid,
    input  logic [REG_ADDR_W-1:0] de_rs1,
    input  logic [REG_ADDR_W-1:0] de_rs2,
    input  logic                  de_rs1_used,
    input  logic                  de_rs2_used,
    output logic                  hit_c
);

    logic rd_live_c;
    logic rs1_match_c;
    logic rs2_match_c;

    // Compare each used source against the load destination.
    always_comb begin
        rd_live_c   = ex_mem_read && (ex_rd != '0) && de_valid;
        rs1_match_c = de_rs1_used && (de_rs1 == ex_rd);
        rs2_match_c = de_rs2_used && (de_rs2 == ex_rd);
        hit_c       = rd_live_c && (rs1_match_c || rs2_match_c);
    end

endmodule

// File: rtl/hazard_recovery_unit.sv
// Hazard recovery for the OTTER pipeline: mispredict redirect + flush,
// load-use stall and data-memory wait hold. A mispredict seen while memory
// is busy is parked and replayed on the first non-busy cycle.
// Optional build macro HAZARD_STATS_EN adds mispredict/stall counters.
module hazard_recovery_unit
    import pipeline_structs_defs::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  BRANCH_PREDICTION_STATUS_t pred_info,
    input  logic                      de_valid,
    input  logic [REG_ADDR_W-1:0]     de_rs1,
    input  logic [REG_ADDR_W-1:0]     de_rs2,
    input  logic                      de_rs1_used,
    input  logic                      de_rs2_used,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_W-1:0]     ex_rd,
    input  logic                      mem_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0]               mispredict_cnt,
    output logic [31:0]               stall_cnt,
`endif
    output logic [2:0]                pc_sel_out,
    output logic                      pc_write,
    output logic                      stall_if_de,
    output logic                      stall_de_ex,
    output logic                      stall_ex_mem,
    output logic                      stall_mem_wb,
    output logic                      flush_if_de,
    output logic                      flush_de_ex
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD =
        FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

    HAZARD_STATE_t           state_q, state_d;
    HAZARD_STATE_t           saved_q, saved_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [PC_SEL_W-1:0]     pend_sel_q, pend_sel_d;

    HAZARD_STATE_t           eff_state_c;
    HAZARD_CTRL_t            ctrl_c;
    logic [PC_SEL_W-1:0]     pc_sel_c;
    logic                    load_use_c;
    logic                    mispredict_c;
    logic                    redirect_c;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .de_valid    (de_valid),
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_rs1_used (de_rs1_used),
        .de_rs2_used (de_rs2_used),
        .hit_c       (load_use_c)
    );

    // Next-state and control: mem_busy > pending replay > load-use > flush/mispredict > normal.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        flush_cnt_d  = flush_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_sel_d   = pend_sel_q;
        ctrl_c       = ctrl_normal();
        pc_sel_c     = PC_SEL_SEQ;
        redirect_c   = 1'b0;

        // MEM_WAIT behaves as whichever state it interrupted.
        eff_state_c  = (state_q == MEM_WAIT) ? saved_q : state_q;
        // Stale operands under load-use mean the branch outcome is untrusted.
        mispredict_c = (eff_state_c == RUN) && de_valid &&
                       pred_info.failed_prediction && !load_use_c;

        if (mem_busy) begin
            ctrl_c  = ctrl_mem_hold();
            state_d = MEM_WAIT;
            saved_d = eff_state_c;
            if (mispredict_c) begin
                pend_valid_d = 1'b1;
                pend_sel_d   = pred_info.pc_sel;
            end
        end else if (pend_valid_q) begin
            ctrl_c       = ctrl_flush();
            pc_sel_c     = pend_sel_q;
            redirect_c   = 1'b1;
            pend_valid_d = 1'b0;
            if (MULTI_FLUSH) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else if (load_use_c) begin
            ctrl_c  = ctrl_load_use();
            state_d = eff_state_c;
        end else if (eff_state_c == FLUSH) begin
            ctrl_c      = ctrl_flush();
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            state_d     = (flush_cnt_q <= FLUSH_CNT_W'(1)) ? RUN : FLUSH;
        end else if (mispredict_c) begin
            ctrl_c     = ctrl_flush();
            pc_sel_c   = pred_info.pc_sel;
            redirect_c = 1'b1;
            if (MULTI_FLUSH) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end

        // Reset overrides the outputs immediately, not just at the next edge.
        if (RST) begin
            ctrl_c     = ctrl_reset();
            pc_sel_c   = PC_SEL_SEQ;
            redirect_c = 1'b0;
        end
    end

    // State, flush counter and parked redirect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= RUN;
            saved_q      <= RUN;
            flush_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_sel_q   <= PC_SEL_SEQ;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            flush_cnt_q  <= flush_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_sel_q   <= pend_sel_d;
        end
    end

    // Drive pipeline-register controls from the bundle.
    always_comb begin
        pc_sel_out   = pc_sel_c;
        pc_write     = ctrl_c.pc_write;
        stall_if_de  = ctrl_c.stall_if_de;
        stall_de_ex  = ctrl_c.stall_de_ex;
        stall_ex_mem = ctrl_c.stall_ex_mem;
        stall_mem_wb = ctrl_c.stall_mem_wb;
        flush_if_de  = ctrl_c.flush_if_de;
        flush_de_ex  = ctrl_c.flush_de_ex;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Accepted redirects and PC-frozen cycles; both wrap naturally.
    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q + {31'd0, redirect_c};
        stall_cnt_d      = stall_cnt_q + {31'd0, !ctrl_c.pc_write};
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mispredict_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            mispredict_cnt_q <= mispredict_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;
    assign stall_cnt      = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_recovery_unit.md
Name: hazard_recovery_unit

Overview:
- Pipeline hazard controller sitting directly downstream of branch prediction in the 5-stage OTTER pipeline.
- Consumes the DE-stage prediction status (pc_sel, failed_prediction); redirects fetch and flushes wrong-path instructions.
- Also detects load-use hazards and holds the pipeline during data-memory wait.
- Drives all stall/flush enables of the IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- FLUSH_CYCLES, 1, cycles flush_if_de stays asserted per mispredict (1..7).
- REG_ADDR_W, 5, register-address width.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- pred_info  input  BRANCH_PREDICTION_STATUS_t  {pc_sel[2:0], failed_prediction} from DE stage.
- de_valid  input  1  DE holds a real (non-bubble) instruction.
- de_rs1, de_rs2  input  REG_ADDR_W  DE source registers.
- de_rs1_used, de_rs2_used  input  1  source actually read.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rd  input  REG_ADDR_W  EX destination register.
- mem_busy  input  1  data memory not ready; hold pipeline.
- pc_sel_out  output  3  next-PC mux select to IF.
- pc_write  output  1  PC register enable.
- stall_if_de, stall_de_ex, stall_ex_mem, stall_mem_wb  output  1 each  register hold enables.
- flush_if_de, flush_de_ex  output  1 each  insert bubble at next edge.

Behaviour:
- States (HAZARD_STATE_t): RUN, FLUSH, MEM_WAIT. Reset -> RUN, flush counter 0, pending-redirect register cleared.
- While RST=1: pc_sel_out=0, pc_write=0, all stalls 0, flush_if_de=flush_de_ex=1.
- Priority per cycle: mem_busy > load-use > mispredict > normal.
- mem_busy=1, any state: all stall_* =1, pc_write=0, flushes 0, pc_sel_out=0. Next state MEM_WAIT; flush counter frozen. Leaving MEM_WAIT returns to the saved state (RUN or FLUSH).
- Load-use: ex_mem_read & ex_rd!=0 & de_valid & ((de_rs1_used & de_rs1==ex_rd) | (de_rs2_used & de_rs2==ex_rd)).
  - Response: pc_write=0, stall_if_de=1, flush_de_ex=1, pc_sel_out=0.
  - failed_prediction is ignored that cycle, since the branch operands are stale.
  - Exactly 1 stall cycle per hazard.
- Mispredict: RUN, de_valid=1, failed_prediction=1, no higher-priority event.
  - Same cycle (combinational): pc_sel_out=pred_info.pc_sel, pc_write=1, flush_if_de=1.
  - If FLUSH_CYCLES>1: enter FLUSH with counter=FLUSH_CYCLES-1. Each FLUSH cycle asserts flush_if_de with pc_sel_out=0 and decrements the counter; return to RUN at 0.
- failed_prediction with de_valid=0, or while in FLUSH: ignored (wrong-path bubble).
- Mispredict coinciding with mem_busy: latch pred_info.pc_sel into the pending register. Apply the redirect plus flush on the first cycle mem_busy falls, then clear the pending register.
- Normal: pc_sel_out=0, pc_write=1, all stalls and flushes 0.
- All outputs are combinational from state plus inputs; only state, counter and pending register are flopped.

Optional Feature:
- HAZARD_STATS_EN defined adds outputs mispredict_cnt[31:0], stall_cnt[31:0].
  - mispredict_cnt increments per accepted redirect (including a deferred one).
  - stall_cnt increments per cycle with pc_write=0 outside reset.
  - Both wrap at 2^32 and clear on RST.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- pipeline_structs_defs package gains:
  - HAZARD_STATE_t enum.
  - HAZARD_CTRL_t struct bundling the stall/flush/pc_write outputs.
  - localparam PC_SEL_SEQ=3'd0.
- BRANCH_PREDICTION_STATUS_t is reused unchanged.
- One combinational sub-module, load_use_detector, computes the load-use hit from the rs/rd/used inputs.

Test Plan:
- Reset pulse mid-FLUSH -> outputs immediately flush=1, stalls=0, pc_write=0; after release: RUN, pc_sel_out=0, pc_write=1.
- pred_info={3'd2,1}, de_valid=1 -> same cycle pc_sel_out=2, flush_if_de=1. With FLUSH_CYCLES=3, flush_if_de held 3 cycles total, then RUN.
- ex_mem_read=1, ex_rd=5, de_rs2=5, de_rs2_used=1, failed_prediction=1 -> one cycle of pc_write=0, stall_if_de=1, flush_de_ex=1, pc_sel_out=0. The redirect is taken on the following cycle.
- mem_busy=1 for 4 cycles with mispredict pc_sel=3 in cycle 1 -> all stalls high for 4 cycles. Cycle 5: pc_sel_out=3, flush_if_de=1.
- ex_rd=0 with load and matching rs1=0 -> no stall.
- HAZARD_STATS_EN: 2 mispredicts + 1 load-use -> mispredict_cnt=2, stall_cnt=1.
